// File: rtl/mesm6_pkg.sv
// Shared MESM-6 fetch definitions: FSM states, word/instruction widths and the
// position of the short/long format bit.
package mesm6_pkg;

  localparam int ADDR_W      = 15;
  localparam int WORD_W      = 48;
  localparam int INSTR_W     = 24;
  localparam int REG_W       = 4;
  localparam int OP_W        = 8;
  localparam int FMT_BIT     = 19;
  localparam int SHORT_OP_W  = 5;
  localparam int LONG_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    LEFT,
    RIGHT
  } fetch_state_e;

  // Word addresses wrap modulo 2^ADDR_W (77777 -> 00000).
  function automatic logic [ADDR_W-1:0] nextWordAddr(input logic [ADDR_W-1:0] addr);
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: instruction-memory handshake plus the decoder-facing
// instruction port, redirect and halt controls.
interface ifetch_if;
  import mesm6_pkg::*;

  logic [ADDR_W-1:0]  o_imem_addr;
  logic               o_imem_read;
  logic [WORD_W-1:0]  i_imem_data;
  logic               i_imem_done;
  logic               o_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [ADDR_W-1:0]  o_pc;
  logic               o_right;
  logic [REG_W-1:0]   o_reg;
  logic               o_long;
  logic [OP_W-1:0]    o_op;
  logic [ADDR_W-1:0]  o_addr;
  logic               i_jump;
  logic [ADDR_W-1:0]  i_jump_addr;
  logic               i_halt;

  modport master (
    output o_imem_addr, o_imem_read, o_valid, o_instr, o_pc, o_right,
           o_reg, o_long, o_op, o_addr,
    input  i_imem_data, i_imem_done, i_ready, i_jump, i_jump_addr, i_halt
  );

  modport slave (
    input  o_imem_addr, o_imem_read, o_valid, o_instr, o_pc, o_right,
           o_reg, o_long, o_op, o_addr,
    output i_imem_data, i_imem_done, i_ready, i_jump, i_jump_addr, i_halt
  );

endinterface

// File: rtl/ifield_decode.sv
// Combinational split of a 24-bit instruction half-word into index register,
// format flag, opcode and address.
module ifield_decode
  import mesm6_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [REG_W-1:0]   reg_o,
  output logic               long_o,
  output logic [OP_W-1:0]    op_o,
  output logic [ADDR_W-1:0]  addr_o
);

  // A set format bit marks the short form: 5-bit opcode, full 15-bit address.
  always_comb begin
    reg_o  = instr_i[INSTR_W-1 -: REG_W];
    long_o = ~instr_i[FMT_BIT];
    if (instr_i[FMT_BIT]) begin
      op_o   = {{(OP_W-SHORT_OP_W){1'b0}}, instr_i[FMT_BIT -: SHORT_OP_W]};
      addr_o = instr_i[ADDR_W-1:0];
    end else begin
      op_o   = instr_i[FMT_BIT -: OP_W];
      addr_o = {{(ADDR_W-LONG_ADDR_W){1'b0}}, instr_i[LONG_ADDR_W-1:0]};
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: reads one 48-bit word per access and presents its left,
// then right, half-word to the decoder, with jump redirect and halt.
module ifetch
  import mesm6_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 15'o00001
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pcNext_d;
  logic [WORD_W-1:0]  buf_q;
  logic               read_q;
  logic               valid_q;
  logic               right_q;
  logic [INSTR_W-1:0] instr;

  assign pcNext_d = nextWordAddr(pc_q);

  // Jump outranks everything but reset; leaving REQ on a jump goes through GAP
  // so the read strobe drops before the redirected access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      buf_q   <= '0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      right_q <= 1'b0;
    end else if (bus.i_jump) begin
      pc_q    <= bus.i_jump_addr;
      buf_q   <= '0;
      valid_q <= 1'b0;
      right_q <= 1'b0;
      if (state_q == REQ) begin
        state_q <= GAP;
        read_q  <= 1'b0;
      end else if (bus.i_halt) begin
        state_q <= IDLE;
        read_q  <= 1'b0;
      end else begin
        state_q <= REQ;
        read_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (!bus.i_halt) begin
            state_q <= REQ;
            read_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (bus.i_imem_done) begin
            buf_q   <= bus.i_imem_data;
            state_q <= LEFT;
            read_q  <= 1'b0;
            valid_q <= 1'b1;
            right_q <= 1'b0;
          end
        end
        LEFT: begin
          if (bus.i_ready) begin
            state_q <= RIGHT;
            right_q <= 1'b1;
          end
        end
        RIGHT: begin
          if (bus.i_ready) begin
            pc_q    <= pcNext_d;
            valid_q <= 1'b0;
            read_q  <= ~bus.i_halt;
            state_q <= bus.i_halt ? IDLE : REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr           = right_q ? buf_q[INSTR_W-1:0] : buf_q[WORD_W-1:INSTR_W];
  assign bus.o_instr     = instr;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_imem_read = read_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_right     = right_q;

  ifield_decode u_decode (
    .instr_i (instr),
    .reg_o   (bus.o_reg),
    .long_o  (bus.o_long),
    .op_o    (bus.o_op),
    .addr_o  (bus.o_addr)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized traffic,
// checked against a transaction-level model of fetch order and decode rules.
module tb_ifetch;

  localparam logic [14:0] START = 15'o00001;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ifetch_if bus ();

  ifetch #(.START_ADDR(START)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [14:0] pc;
    logic        right;
    logic [23:0] instr;
  } expInstr_t;

  expInstr_t   expQ[$];
  logic [14:0] expPc;
  logic        expRead;
  logic [47:0] memOverride [logic [14:0]];
  int          memWait;
  int          latency;
  bit          randLat;
  int          checks;
  int          errors;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] memWord(input logic [14:0] a);
    if (memOverride.exists(a)) return memOverride[a];
    return (({33'd0, a} + 48'd1) * 48'h9E3779B97F4B) ^ 48'h5A5AC3C30F0F;
  endfunction

  function automatic void refDecode(input logic [23:0] ins, output logic [3:0] r,
                                    output logic l, output logic [7:0] op,
                                    output logic [14:0] a);
    r = ins[23:20];
    l = ~ins[19];
    if (ins[19]) begin
      op = {3'b000, ins[19:15]};
      a  = ins[14:0];
    end else begin
      op = ins[19:12];
      a  = {3'b000, ins[11:0]};
    end
  endfunction

  // The model tracks only which word must be read next, whether a read is owed,
  // and the queue of half-words the decoder must see, in order.
  task automatic modelUpdate(input bit rst, input bit jmp, input logic [14:0] jaddr,
                             input bit hlt, input bit rdy, input bit done);
    expInstr_t   e;
    logic [47:0] w;
    if (rst) begin
      expQ.delete();
      expPc   = START;
      expRead = 1'b0;
    end else if (jmp) begin
      expQ.delete();
      expPc   = jaddr;
      expRead = !expRead && !hlt;
    end else if (expRead) begin
      if (done) begin
        w = memWord(expPc);
        e.pc = expPc; e.right = 1'b0; e.instr = w[47:24];
        expQ.push_back(e);
        e.right = 1'b1; e.instr = w[23:0];
        expQ.push_back(e);
        expRead = 1'b0;
      end
    end else begin
      if (expQ.size() != 0 && rdy) begin
        e = expQ.pop_front();
        if (e.right) expPc = expPc + 15'd1;
      end
      expRead = (expQ.size() == 0) && !hlt;
    end
  endtask

  task automatic checkState(input bit rst);
    logic [3:0]  r;
    logic        l;
    logic [7:0]  op;
    logic [14:0] a;
    checkOutput("read", 64'(bus.o_imem_read), 64'(expRead));
    if (expRead) checkOutput("imemAddr", 64'(bus.o_imem_addr), 64'(expPc));
    checkOutput("valid", 64'(bus.o_valid), 64'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      refDecode(expQ[0].instr, r, l, op, a);
      checkOutput("instr", 64'(bus.o_instr), 64'(expQ[0].instr));
      checkOutput("pc",    64'(bus.o_pc),    64'(expQ[0].pc));
      checkOutput("right", 64'(bus.o_right), 64'(expQ[0].right));
      checkOutput("reg",   64'(bus.o_reg),   64'(r));
      checkOutput("long",  64'(bus.o_long),  64'(l));
      checkOutput("op",    64'(bus.o_op),    64'(op));
      checkOutput("addr",  64'(bus.o_addr),  64'(a));
    end
    if (rst) begin
      checkOutput("rstRight", 64'(bus.o_right), 64'd0);
      checkOutput("rstPc",    64'(bus.o_pc),    64'(START));
    end
  endtask

  // One clock: the memory responds to the read it currently sees, inputs are
  // applied, and after the edge the model advances and outputs are compared.
  task automatic applyStimulus(input bit rst, input bit jmp, input logic [14:0] jaddr,
                               input bit hlt, input bit rdy, input bit forceDone);
    bit          done;
    logic [47:0] data;
    if (bus.o_imem_read === 1'b1) begin
      done = (memWait == 0);
      if (memWait != 0) memWait--;
    end else begin
      done    = 1'b0;
      memWait = randLat ? int'($urandom_range(0, 3)) : latency;
    end
    if (forceDone) done = 1'b1;
    data = done ? memWord(bus.o_imem_addr) : {16'($urandom), $urandom};
    reset           = rst;
    bus.i_jump      = jmp;
    bus.i_jump_addr = jaddr;
    bus.i_halt      = hlt;
    bus.i_ready     = rdy;
    bus.i_imem_done = done;
    bus.i_imem_data = data;
    @(posedge clk);
    #1;
    modelUpdate(rst, jmp, jaddr, hlt, rdy, done);
    checkState(rst);
  endtask

  task automatic waitValid(input bit rdy, input bit hlt, input string tag);
    int n;
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 50) begin
      applyStimulus(1'b0, 1'b0, 15'd0, hlt, rdy, 1'b0);
      n++;
    end
    checkOutput(tag, 64'(bus.o_valid), 64'd1);
  endtask

  initial begin
    bit          rst, jmp, hlt, rdy;
    logic [14:0] jaddr;
    checks  = 0;
    errors  = 0;
    expPc   = START;
    expRead = 1'b0;
    memWait = 0;
    latency = 1;
    randLat = 1'b0;
    reset           = 1'b1;
    bus.i_jump      = 1'b0;
    bus.i_jump_addr = '0;
    bus.i_halt      = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_imem_done = 1'b0;
    bus.i_imem_data = '0;
    memOverride[15'o00001] = {24'h2A0000, 24'h1C8002};
    memOverride[15'o00002] = {24'h124003, 24'h0F0000};

    repeat (3) applyStimulus(1'b1, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);

    // First cycle after reset is IDLE; the read follows in the next one.
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("firstRead", 64'(bus.o_imem_read), 64'd1);
    checkOutput("firstReadAddr", 64'(bus.o_imem_addr), 64'd1);

    waitValid(1'b1, 1'b0, "waitLeft1");
    checkOutput("leftInstr", 64'(bus.o_instr), 64'h2A0000);
    checkOutput("leftReg", 64'(bus.o_reg), 64'd2);
    checkOutput("leftOp", 64'(bus.o_op), 64'o24);
    checkOutput("leftAddr", 64'(bus.o_addr), 64'd0);
    checkOutput("leftRight", 64'(bus.o_right), 64'd0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rightInstr", 64'(bus.o_instr), 64'h1C8002);
    checkOutput("rightReg", 64'(bus.o_reg), 64'd1);
    checkOutput("rightOp", 64'(bus.o_op), 64'o31);
    checkOutput("rightAddr", 64'(bus.o_addr), 64'd2);
    checkOutput("rightRight", 64'(bus.o_right), 64'd1);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("secondReadAddr", 64'(bus.o_imem_addr), 64'd2);

    waitValid(1'b0, 1'b0, "waitLeft2");
    checkOutput("longFlag", 64'(bus.o_long), 64'd1);
    checkOutput("longOp", 64'(bus.o_op), 64'o044);
    checkOutput("longAddr", 64'(bus.o_addr), 64'd3);
    checkOutput("longReg", 64'(bus.o_reg), 64'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("stallInstr", 64'(bus.o_instr), 64'h124003);
    checkOutput("stallNoRead", 64'(bus.o_imem_read), 64'd0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("thirdReadAddr", 64'(bus.o_imem_addr), 64'd3);

    // Jump arriving together with done: data dropped, one idle cycle, then addr 7.
    checkOutput("preJumpRead", 64'(bus.o_imem_read), 64'd1);
    applyStimulus(1'b0, 1'b1, 15'd7, 1'b0, 1'b0, 1'b1);
    checkOutput("gapRead", 64'(bus.o_imem_read), 64'd0);
    checkOutput("gapValid", 64'(bus.o_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("jumpReadAddr", 64'(bus.o_imem_addr), 64'd7);
    waitValid(1'b0, 1'b0, "waitJumpLeft");
    checkOutput("jumpPc", 64'(bus.o_pc), 64'd7);
    checkOutput("jumpRight", 64'(bus.o_right), 64'd0);

    // Halt while the right half is accepted parks the fetcher in IDLE.
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("haltNoRead", 64'(bus.o_imem_read), 64'd0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("resumeRead", 64'(bus.o_imem_read), 64'd1);
    checkOutput("resumeAddr", 64'(bus.o_imem_addr), 64'd8);

    // Program counter wrap from 77777.
    applyStimulus(1'b0, 1'b1, 15'o77777, 1'b0, 1'b0, 1'b0);
    waitValid(1'b0, 1'b0, "waitWrapLeft");
    checkOutput("wrapPc", 64'(bus.o_pc), 64'o77777);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrapReadAddr", 64'(bus.o_imem_addr), 64'd0);

    // Reset during a read, with done arriving in the reset cycle.
    applyStimulus(1'b1, 1'b0, 15'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lateDoneIgnored", 64'(bus.o_valid), 64'd0);
    checkOutput("postResetAddr", 64'(bus.o_imem_addr), 64'(START));

    randLat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      jmp   = ($urandom_range(0, 24) == 0);
      jaddr = ($urandom_range(0, 3) == 0) ? 15'(15'o77776 + $urandom_range(0, 1))
                                           : 15'($urandom);
      hlt   = ($urandom_range(0, 5) == 0);
      rdy   = ($urandom_range(0, 9) < 7);
      applyStimulus(rst, jmp, jaddr, hlt, rdy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
